// File: rtl/prbs_ask_src_if.sv
// Symbol/sample bus of the PRBS 4-ASK source: enables in, symbols and upsampled samples out.
// master = the source block, slave = the consumer side that also supplies the enables.
interface prbs_ask_src_if #(
  parameter int OUT_W = 18
);
  logic                    sam_clk_en;
  logic                    sym_clk_en;
  logic [1:0]              sym_out;
  logic                    sym_valid;
  logic signed [OUT_W-1:0] samp_out;
  logic                    samp_valid;
  logic                    sync_err;

  modport master (
    input  sam_clk_en, sym_clk_en,
    output sym_out, sym_valid, samp_out, samp_valid, sync_err
  );

  modport slave (
    output sam_clk_en, sym_clk_en,
    input  sym_out, sym_valid, samp_out, samp_valid, sync_err
  );
endinterface

// File: rtl/prbs_ask_src.sv
// PRBS15 -> Gray 4-ASK -> x4 upsampled 1s17 sample source with enable-alignment monitor.
// Optional macro ZOH_EN: zero-order hold on phases 1..3 instead of zero-stuffing.
module prbs_ask_src #(
  parameter logic [14:0] SEED  = 15'h0001,
  parameter int          OUT_W = 18,
  parameter int          LVL_A = 32768
) (
  input  logic          clk,
  input  logic          reset,
  prbs_ask_src_if.master bus
);

  localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h0001 : SEED;
  localparam logic signed [OUT_W-1:0] L_A  = OUT_W'(LVL_A);
  localparam logic signed [OUT_W-1:0] L_3A = OUT_W'(3 * LVL_A);
  localparam logic [1:0] PH_SYM = 2'd0;

  function automatic logic signed [OUT_W-1:0] map_level(input logic [1:0] sym);
    case (sym)
      2'b00:   map_level = -L_3A;
      2'b01:   map_level = -L_A;
      2'b11:   map_level = L_A;
      default: map_level = L_3A;
    endcase
  endfunction

  logic [14:0]             r_lfsr;
  logic [1:0]              r_phase;
  logic [1:0]              r_sym_out;
  logic                    r_sym_valid;
  logic signed [OUT_W-1:0] r_samp_out;
  logic                    r_samp_valid;
  logic                    r_sync_err;

  // Two Fibonacci steps folded into one cycle: b1 = s14^s13, then b0 = s13^s12.
  logic                    w_b1;
  logic                    w_b0;
  logic [14:0]             w_lfsr_next;
  logic signed [OUT_W-1:0] w_new_level;
  logic signed [OUT_W-1:0] w_fill_level;

  assign w_b1        = r_lfsr[14] ^ r_lfsr[13];
  assign w_b0        = r_lfsr[13] ^ r_lfsr[12];
  assign w_lfsr_next = {r_lfsr[12:0], w_b1, w_b0};
  assign w_new_level = map_level({w_b1, w_b0});

`ifdef ZOH_EN
  assign w_fill_level = map_level(r_sym_out);
`else
  assign w_fill_level = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= SEED_EFF;
      r_phase      <= PH_SYM;
      r_sym_out    <= '0;
      r_sym_valid  <= 1'b0;
      r_samp_out   <= '0;
      r_samp_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_sym_valid  <= 1'b0;
      r_samp_valid <= 1'b0;

      if (bus.sym_clk_en) begin
        r_lfsr      <= w_lfsr_next;
        r_sym_out   <= {w_b1, w_b0};
        r_sym_valid <= 1'b1;
      end

      if (bus.sym_clk_en && bus.sam_clk_en) begin
        r_phase      <= 2'd1;
        r_samp_out   <= w_new_level;
        r_samp_valid <= 1'b1;
      end else if (bus.sym_clk_en) begin
        // Symbol arrived between samples: it is taken, but no sample is emitted.
        r_sync_err <= 1'b1;
      end else if (bus.sam_clk_en) begin
        r_phase      <= r_phase + 2'd1;
        r_samp_valid <= 1'b1;
        if (r_phase == PH_SYM) begin
          r_sync_err <= 1'b1;
          r_samp_out <= '0;
        end else begin
          r_samp_out <= w_fill_level;
        end
      end
    end
  end

  assign bus.sym_out    = r_sym_out;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.samp_out   = r_samp_out;
  assign bus.samp_valid = r_samp_valid;
  assign bus.sync_err   = r_sync_err;

endmodule

// File: tb/tb_prbs_ask_src.sv
// Self-checking bench for prbs_ask_src: behavioural PRBS/ASK model, per-cycle compare, literal pins.
module tb_prbs_ask_src;

  localparam int  OUT_W = 18;
  localparam longint A  = 32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_ask_src_if #(.OUT_W(OUT_W)) bus ();

  prbs_ask_src #(.SEED(15'h0001), .OUT_W(OUT_W), .LVL_A(32768)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gray 4-ASK: 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a
  function automatic longint level(input logic [1:0] s);
    case (s)
      2'b00:   return -3 * A;
      2'b01:   return -A;
      2'b11:   return A;
      default: return 3 * A;
    endcase
  endfunction

  // One PRBS15 step as plain integer arithmetic; the emitted bit is the LSB of the result.
  function automatic int prbs_next(input int s);
    int fb;
    fb = ((s >> 14) ^ (s >> 13)) & 1;
    return ((s << 1) | fb) & 32'h7fff;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_lfsr  = 1;
  int          m_since = 0;   // samples since the last symbol sample
  bit          m_ready = 0;
  logic [1:0]  e_sym   = '0;
  longint      e_samp  = 0;
  bit          e_symv  = 0;
  bit          e_sampv = 0;
  bit          e_err   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr  = 1;
      m_since = 0;
      e_sym   = '0;
      e_samp  = 0;
      e_symv  = 0;
      e_sampv = 0;
      e_err   = 0;
      m_ready = 1;
    end else begin
      e_symv  = 0;
      e_sampv = 0;
      if (bus.sym_clk_en) begin
        m_lfsr   = prbs_next(m_lfsr);
        e_sym[1] = m_lfsr[0];
        m_lfsr   = prbs_next(m_lfsr);
        e_sym[0] = m_lfsr[0];
        e_symv   = 1;
      end
      if (bus.sym_clk_en && bus.sam_clk_en) begin
        e_samp  = level(e_sym);
        e_sampv = 1;
        m_since = 1;
      end else if (bus.sym_clk_en) begin
        e_err = 1;
      end else if (bus.sam_clk_en) begin
        e_sampv = 1;
        if (m_since % 4 == 0) begin
          e_err  = 1;
          e_samp = 0;
        end else begin
`ifdef ZOH_EN
          e_samp = level(e_sym);
`else
          e_samp = 0;
`endif
        end
        m_since++;
      end
    end
  end

  // ---------------- compare + capture ----------------
  bit     cap_en = 0;
  longint cap_sym[$];
  longint cap_symsamp[$];
  longint cap_samp[$];

  always @(negedge clk) begin
    if (m_ready) begin
      check("sym_out",    bus.sym_out,               e_sym);
      check("sym_valid",  bus.sym_valid,             e_symv);
      check("samp_out",   $signed(bus.samp_out),     e_samp);
      check("samp_valid", bus.samp_valid,            e_sampv);
      check("sync_err",   bus.sync_err,              e_err);
    end
    if (cap_en) begin
      if (bus.sym_valid) begin
        cap_sym.push_back(longint'(bus.sym_out));
        cap_symsamp.push_back($signed(bus.samp_out));
      end
      if (bus.samp_valid) cap_samp.push_back($signed(bus.samp_out));
    end
  end

  // ---------------- stimulus ----------------
  int gen_cnt = 0;

  task automatic step(input bit sam, input bit sym, input bit r);
    @(negedge clk);
    #1;
    bus.sam_clk_en = sam;
    bus.sym_clk_en = sym;
    rst            = r;
  endtask

  task automatic nominal(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      step(gen_cnt % 4 == 0, gen_cnt == 0, 1'b0);
      gen_cnt = (gen_cnt + 1) % 16;
    end
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) step(1'($urandom), 1'($urandom), 1'b1);
    gen_cnt = 0;
  endtask

  task automatic clear_caps();
    cap_sym.delete();
    cap_symsamp.delete();
    cap_samp.delete();
  endtask

  initial begin
    logic [1:0] lit_sym [8];
    int s;
    logic [1:0] msym;
    lit_sym = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    bus.sam_clk_en = 1'b0;
    bus.sym_clk_en = 1'b0;

    // Model pin: first eight symbols of PRBS15 from seed 1.
    s = 1;
    for (int k = 0; k < 8; k++) begin
      s = prbs_next(s); msym[1] = s[0];
      s = prbs_next(s); msym[0] = s[0];
      check("model_sym", msym, lit_sym[k]);
    end

    // Reset with enables toggling, then the reset state right after release.
    do_reset(4);
    step(1'b0, 1'b0, 1'b0);
    check("rst_samp_out", $signed(bus.samp_out), 0);
    check("rst_sync_err", bus.sync_err, 0);

    // Nominal run from seed 1.
    clear_caps();
    cap_en = 1;
    nominal(16 * 9);
    cap_en = 0;
    check("nom_nsym", cap_sym.size(), 9);
    for (int k = 0; k < 8 && k < cap_sym.size(); k++) begin
      check("nom_sym", cap_sym[k], lit_sym[k]);
      check("nom_sym_samp", cap_symsamp[k], level(lit_sym[k]));
    end
    for (int k = 0; k < 8 && k < cap_samp.size(); k++) begin
`ifdef ZOH_EN
      check("nom_samp_zoh", cap_samp[k], -98304);
`else
      check("nom_samp_zs", cap_samp[k], (k % 4 == 0) ? -98304 : 0);
`endif
    end
    check("nom_sync_err", bus.sync_err, 0);

    // Symbol enable without a sample enable mid-stream.
    nominal(6);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    gen_cnt = (gen_cnt + 2) % 16;
    check("symalone_err", bus.sync_err, 1);
    check("symalone_sampv", bus.samp_valid, 0);
    nominal(40);
    check("symalone_sticky", bus.sync_err, 1);

    // Suppressed symbol enable: fifth sample without a symbol.
    do_reset(2);
    nominal(16 * 2);
    step(1'b1, 1'b0, 1'b0);
    gen_cnt = 1;
    nominal(1);
    check("supp_err", bus.sync_err, 1);
    check("supp_samp", $signed(bus.samp_out), 0);
    check("supp_sampv", bus.samp_valid, 1);
    nominal(31);

    // Reset while at phase 2, then restart with aligned enables.
    do_reset(1);
    nominal(16 * 2 + 6);
    do_reset(2);
    clear_caps();
    cap_en = 1;
    nominal(16 * 7);
    cap_en = 0;
    check("rst2_nsym", cap_sym.size(), 7);
    for (int k = 0; k < 7 && k < cap_sym.size(); k++)
      check("rst2_samp", cap_symsamp[k], level(lit_sym[k]));
    check("rst2_sync_err", bus.sync_err, 0);

    // Randomized: mostly nominal enables with injected faults and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit sam, sym;
      r   = int'($urandom_range(0, 999));
      sam = (gen_cnt % 4 == 0);
      sym = (gen_cnt == 0);
      if (r < 30)       sym = ~sym;
      else if (r < 50)  sam = ~sam;
      if (r >= 995) do_reset(1 + int'($urandom_range(0, 2)));
      else begin
        step(sam, sym, 1'b0);
        gen_cnt = (gen_cnt + 1) % 16;
      end
    end

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
